// File: rtl/dbg_entry_ctrl_pkg.sv
// Shared types and constants for the debug entry/exit controller.
// Address width, dcsr.cause codes and FSM state encoding.
package dbg_entry_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  localparam logic [2:0] DBG_CAUSE_NONE    = 3'd0;
  localparam logic [2:0] DBG_CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] DBG_CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] DBG_CAUSE_STEP    = 3'd4;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2,
    StResume = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/dbg_cause_arb.sv
// Combinational priority encoder for debug entry causes:
// trigger > ebreak > haltreq > step.
module dbg_cause_arb
  import dbg_entry_ctrl_pkg::*;
(
  input  logic       trigger,
  input  logic       ebreak,
  input  logic       haltreq,
  input  logic       step,
  output logic       valid,
  output logic [2:0] cause
);

  always_comb begin
    valid = trigger | ebreak | haltreq | step;
    cause = DBG_CAUSE_NONE;
    if (trigger) begin
      cause = DBG_CAUSE_TRIGGER;
    end else if (ebreak) begin
      cause = DBG_CAUSE_EBREAK;
    end else if (haltreq) begin
      cause = DBG_CAUSE_HALTREQ;
    end else if (step) begin
      cause = DBG_CAUSE_STEP;
    end
  end

endmodule

// File: rtl/dbg_entry_ctrl.sv
// Debug-mode entry/exit controller: arbitrates entry cause, captures dpc, drains, halts, resumes.
// Optional single-step support is enabled by defining DBG_STEP_EN (adds the dcsr_step input).
module dbg_entry_ctrl
  import dbg_entry_ctrl_pkg::*;
(
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  breakpoint,
  input  logic                  breakpoint_exp,
  input  logic                  ebreak_ex,
  input  logic                  dcsr_ebreakm,
  input  logic                  haltreq,
  input  logic                  resumereq,
`ifdef DBG_STEP_EN
  input  logic                  dcsr_step,
`endif
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic                  pipe_idle,
  input  logic                  retire_valid,
  input  logic                  dpc_wr_en,
  input  logic [ADDR_WIDTH-1:0] dpc_wr_data,
  output logic                  dbg_mode,
  output logic                  dbg_flush,
  output logic                  halted,
  output logic                  resumeack,
  output logic [ADDR_WIDTH-1:0] dpc,
  output logic [2:0]            dcsr_cause,
  output logic                  resume_valid,
  output logic [ADDR_WIDTH-1:0] resume_pc,
  output logic                  exp_req,
  output logic [ADDR_WIDTH-1:0] exp_pc
);

  dbg_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_ex_dly_q;
  logic [ADDR_WIDTH-1:0] dpc_q, dpc_d;
  logic [2:0]            cause_q, cause_d;
  logic                  flush_q, flush_d;
  logic                  resumeack_q, resumeack_d;
  logic                  exp_req_q, exp_req_d;
  logic [ADDR_WIDTH-1:0] exp_pc_q, exp_pc_d;
  logic                  step_pending_q, step_pending_d;
  logic                  step_arm;
  logic                  step_done;
  logic                  entry_valid;
  logic [2:0]            entry_cause;

`ifdef DBG_STEP_EN
  assign step_arm = dcsr_step;
`else
  assign step_arm = 1'b0;
`endif

  // Without step support step_pending never sets, so step_done stays 0.
  assign step_done = step_pending_q & retire_valid;

  dbg_cause_arb u_cause_arb (
    .trigger (breakpoint),
    .ebreak  (ebreak_ex & dcsr_ebreakm),
    .haltreq (haltreq),
    .step    (step_done),
    .valid   (entry_valid),
    .cause   (entry_cause)
  );

  always_comb begin
    state_d        = state_q;
    dpc_d          = dpc_q;
    cause_d        = cause_q;
    flush_d        = 1'b0;
    resumeack_d    = 1'b0;
    exp_req_d      = 1'b0;
    exp_pc_d       = exp_pc_q;
    step_pending_d = step_pending_q;
    unique case (state_q)
      StRun: begin
        if (entry_valid) begin
          state_d        = StDrain;
          cause_d        = entry_cause;
          // Trigger hits are registered upstream and belong to the previous EX pc.
          dpc_d          = (entry_cause == DBG_CAUSE_TRIGGER) ? pc_ex_dly_q : pc_ex;
          flush_d        = 1'b1;
          step_pending_d = 1'b0;
        end else if (breakpoint_exp) begin
          exp_req_d = 1'b1;
          exp_pc_d  = pc_ex_dly_q;
        end
      end
      StDrain: begin
        if (pipe_idle) state_d = StHalted;
      end
      StHalted: begin
        if (dpc_wr_en) dpc_d = dpc_wr_data;
        if (resumereq) state_d = StResume;
      end
      StResume: begin
        state_d        = StRun;
        resumeack_d    = 1'b1;
        step_pending_d = step_arm;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q        <= StRun;
      pc_ex_dly_q    <= '0;
      dpc_q          <= '0;
      cause_q        <= DBG_CAUSE_NONE;
      flush_q        <= 1'b0;
      resumeack_q    <= 1'b0;
      exp_req_q      <= 1'b0;
      exp_pc_q       <= '0;
      step_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_ex_dly_q    <= pc_ex;
      dpc_q          <= dpc_d;
      cause_q        <= cause_d;
      flush_q        <= flush_d;
      resumeack_q    <= resumeack_d;
      exp_req_q      <= exp_req_d;
      exp_pc_q       <= exp_pc_d;
      step_pending_q <= step_pending_d;
    end
  end

  assign dbg_mode     = (state_q != StRun);
  assign dbg_flush    = flush_q;
  assign halted       = (state_q == StHalted);
  assign resumeack    = resumeack_q;
  assign dpc          = dpc_q;
  assign dcsr_cause   = cause_q;
  assign resume_valid = (state_q == StResume);
  assign resume_pc    = dpc_q;
  assign exp_req      = exp_req_q;
  assign exp_pc       = exp_pc_q;

endmodule

// File: tb/tb_dbg_entry_ctrl.sv
// Directed self-checking bench for dbg_entry_ctrl; step cases run when DBG_STEP_EN is defined.
module tb_dbg_entry_ctrl;
  import dbg_entry_ctrl_pkg::*;

  logic                  cpu_clk = 1'b0;
  logic                  cpu_rstn;
  logic                  breakpoint, breakpoint_exp, ebreak_ex, dcsr_ebreakm;
  logic                  haltreq, resumereq, pipe_idle, retire_valid, dpc_wr_en;
  logic [ADDR_WIDTH-1:0] pc_ex, dpc_wr_data;
  logic                  dbg_mode, dbg_flush, halted, resumeack, resume_valid, exp_req;
  logic [ADDR_WIDTH-1:0] dpc, resume_pc, exp_pc;
  logic [2:0]            dcsr_cause;
`ifdef DBG_STEP_EN
  logic                  dcsr_step;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 cpu_clk = ~cpu_clk;

  dbg_entry_ctrl dut (
    .cpu_clk        (cpu_clk),
    .cpu_rstn       (cpu_rstn),
    .breakpoint     (breakpoint),
    .breakpoint_exp (breakpoint_exp),
    .ebreak_ex      (ebreak_ex),
    .dcsr_ebreakm   (dcsr_ebreakm),
    .haltreq        (haltreq),
    .resumereq      (resumereq),
`ifdef DBG_STEP_EN
    .dcsr_step      (dcsr_step),
`endif
    .pc_ex          (pc_ex),
    .pipe_idle      (pipe_idle),
    .retire_valid   (retire_valid),
    .dpc_wr_en      (dpc_wr_en),
    .dpc_wr_data    (dpc_wr_data),
    .dbg_mode       (dbg_mode),
    .dbg_flush      (dbg_flush),
    .halted         (halted),
    .resumeack      (resumeack),
    .dpc            (dpc),
    .dcsr_cause     (dcsr_cause),
    .resume_valid   (resume_valid),
    .resume_pc      (resume_pc),
    .exp_req        (exp_req),
    .exp_pc         (exp_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    cpu_rstn       = 1'b0;
    breakpoint     = 1'b0;
    breakpoint_exp = 1'b0;
    ebreak_ex      = 1'b0;
    dcsr_ebreakm   = 1'b0;
    haltreq        = 1'b0;
    resumereq      = 1'b0;
    pipe_idle      = 1'b0;
    retire_valid   = 1'b0;
    dpc_wr_en      = 1'b0;
    dpc_wr_data    = '0;
    pc_ex          = '0;
`ifdef DBG_STEP_EN
    dcsr_step      = 1'b0;
`endif
    #12;
    check("rst_dbg_mode", dbg_mode, 0);
    check("rst_flush", dbg_flush, 0);
    check("rst_halted", halted, 0);
    check("rst_dpc", dpc, 0);
    check("rst_cause", dcsr_cause, 0);
    check("rst_exp_req", exp_req, 0);
    check("rst_resume_valid", resume_valid, 0);
    tick();
    cpu_rstn = 1'b1;

    // Trigger breakpoint pairs with previous-cycle pc.
    pc_ex = 32'h100;
    tick();
    pc_ex      = 32'h104;
    breakpoint = 1'b1;
    tick();
    check("bp_flush", dbg_flush, 1);
    check("bp_dbg_mode", dbg_mode, 1);
    check("bp_cause", dcsr_cause, DBG_CAUSE_TRIGGER);
    check("bp_dpc", dpc, 32'h100);
    check("bp_not_halted", halted, 0);
    breakpoint = 1'b0;
    tick();
    check("drain_flush_pulse", dbg_flush, 0);
    check("drain_wait", halted, 0);
    pipe_idle = 1'b1;
    tick();
    check("halted", halted, 1);

    // dpc write and ignored breakpoint while halted, then resume.
    breakpoint  = 1'b1;
    dpc_wr_en   = 1'b1;
    dpc_wr_data = 32'h400;
    tick();
    check("dpc_write", dpc, 32'h400);
    check("halted_bp_ignored_cause", dcsr_cause, DBG_CAUSE_TRIGGER);
    check("halted_bp_no_flush", dbg_flush, 0);
    breakpoint = 1'b0;
    dpc_wr_en  = 1'b0;
    resumereq  = 1'b1;
    tick();
    check("resume_valid", resume_valid, 1);
    check("resume_pc", resume_pc, 32'h400);
    check("resume_halted_low", halted, 0);
    check("resume_dbg_mode", dbg_mode, 1);
    resumereq = 1'b0;
    tick();
    check("run_dbg_mode", dbg_mode, 0);
    check("resumeack", resumeack, 1);
    check("resume_valid_pulse", resume_valid, 0);
    tick();
    check("resumeack_pulse", resumeack, 0);

    // Breakpoint exception forwarded in RUN.
    pc_ex = 32'h200;
    tick();
    pc_ex          = 32'h204;
    breakpoint_exp = 1'b1;
    tick();
    check("exp_req", exp_req, 1);
    check("exp_pc", exp_pc, 32'h200);
    check("exp_no_dbg", dbg_mode, 0);
    breakpoint_exp = 1'b0;
    tick();
    check("exp_req_pulse", exp_req, 0);

    // ebreak only enters when dcsr.ebreakm set.
    pc_ex     = 32'h300;
    ebreak_ex = 1'b1;
    tick();
    check("ebreak_m0_no_entry", dbg_mode, 0);
    dcsr_ebreakm = 1'b1;
    tick();
    check("ebreak_entry", dbg_mode, 1);
    check("ebreak_cause", dcsr_cause, DBG_CAUSE_EBREAK);
    check("ebreak_dpc", dpc, 32'h300);
    ebreak_ex = 1'b0;
    tick();
    check("ebreak_halted", halted, 1);
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0;
    tick();
    check("ebreak_back_run", dbg_mode, 0);

    // Simultaneous causes: trigger wins; haltreq held through resume re-enters.
    pc_ex = 32'h500;
    tick();
    pc_ex      = 32'h504;
    breakpoint = 1'b1;
    haltreq    = 1'b1;
    ebreak_ex  = 1'b1;
    tick();
    check("prio_cause", dcsr_cause, DBG_CAUSE_TRIGGER);
    check("prio_dpc", dpc, 32'h500);
    breakpoint = 1'b0;
    ebreak_ex  = 1'b0;
    tick();
    check("prio_halted", halted, 1);
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0;
    pc_ex     = 32'h600;
    tick();
    check("reenter_ack", resumeack, 1);
    check("reenter_run", dbg_mode, 0);
    tick();
    check("reenter_dbg_mode", dbg_mode, 1);
    check("reenter_cause", dcsr_cause, DBG_CAUSE_HALTREQ);
    check("reenter_dpc", dpc, 32'h600);
    haltreq   = 1'b0;
    pipe_idle = 1'b0;
    tick();
    check("drain_hold", halted, 0);

    // Asynchronous reset mid-drain.
    #2;
    cpu_rstn = 1'b0;
    #1;
    check("rstd_dbg_mode", dbg_mode, 0);
    check("rstd_dpc", dpc, 0);
    check("rstd_cause", dcsr_cause, 0);
    check("rstd_flush", dbg_flush, 0);
    tick();
    cpu_rstn  = 1'b1;
    pipe_idle = 1'b1;
    tick();
    check("rstd_stays_run", dbg_mode, 0);
    check("rstd_not_halted", halted, 0);

`ifdef DBG_STEP_EN
    dcsr_step = 1'b1;
    haltreq   = 1'b1;
    tick();
    haltreq = 1'b0;
    tick();
    check("step_setup_halted", halted, 1);
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0;
    tick();
    check("step_run", dbg_mode, 0);
    dcsr_step    = 1'b0;
    retire_valid = 1'b1;
    pc_ex        = 32'h404;
    tick();
    retire_valid = 1'b0;
    check("step_entry", dbg_mode, 1);
    check("step_cause", dcsr_cause, DBG_CAUSE_STEP);
    check("step_dpc", dpc, 32'h404);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
